// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding, default 100 MHz timing and counter sizing for the debounce bank.
package debounce_pkg;
  typedef enum logic [1:0] {ST_LOW, ST_WAIT_HIGH, ST_HIGH, ST_WAIT_LOW} deb_state_t;
  localparam int DEB_CYCLES_20MS = 2_000_000;
  localparam int LONG_CYCLES_1S  = 100_000_000;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel - 2-FF synchroniser, debounce FSM, strobes and, with
// DEBOUNCE_LONGPRESS_EN defined, a saturating hold counter driving the long-press strobe.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
`ifdef DEBOUNCE_LONGPRESS_EN
  parameter int LONG_CYCLES = 32,
`endif
  parameter int W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_out,
  output logic o_rise,
  output logic o_fall,
  output logic o_long
);
  localparam logic [W-1:0] DEB = W'(DEBOUNCE_CYCLES);
  logic [1:0] r_sync;
  deb_state_t r_state, w_state_nxt;
  logic [W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic r_out, r_rise, r_fall, w_rise, w_fall, w_sync, w_cand;
  assign w_sync    = r_sync[1];
  assign w_cand    = (r_state == ST_WAIT_HIGH);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    case (r_state)
      ST_LOW: if (w_sync) begin
        w_state_nxt = ST_WAIT_HIGH;
        w_cnt_nxt   = W'(1);
      end
      ST_HIGH: if (!w_sync) begin
        w_state_nxt = ST_WAIT_LOW;
        w_cnt_nxt   = W'(1);
      end
      default: if (w_sync != w_cand) begin
        w_state_nxt = w_cand ? ST_LOW : ST_HIGH;
        w_cnt_nxt   = '0;
      end else if (w_cnt_inc == DEB) begin
        w_state_nxt = w_cand ? ST_HIGH : ST_LOW;
        w_cnt_nxt   = '0;
        w_rise      = w_cand;
        w_fall      = !w_cand;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= '0;
      r_state <= ST_LOW;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_rise | (r_out & ~w_fall);
      r_rise  <= w_rise;
      r_fall  <= w_fall;
    end
  end
  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;
`ifdef DEBOUNCE_LONGPRESS_EN
  localparam logic [W-1:0] LONG = W'(LONG_CYCLES);
  logic [W-1:0] r_hold;
  logic r_long, w_hold_run;
  // a pending release stops the hold count, so release always beats the long strobe
  assign w_hold_run = (r_state == ST_HIGH) && w_sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_hold <= !w_hold_run ? '0 : (r_hold == LONG) ? r_hold : r_hold + 1'b1;
      r_long <= w_hold_run && (r_hold == LONG - 1'b1);
    end
  end
  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounced buttons with press/release strobes;
// long-press strobes are built only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEB_CYCLES_20MS,
  parameter int LONG_CYCLES     = LONG_CYCLES_1S
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] button_out,
  output logic [N_CH-1:0] button_rise,
  output logic [N_CH-1:0] button_fall,
  output logic [N_CH-1:0] button_long
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  if (N_CH < 1) begin : g_chk_nch
    $error("debounce_bank: N_CH must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
    $error("debounce_bank: DEBOUNCE_CYCLES must be >= 2");
  end
`ifdef DEBOUNCE_LONGPRESS_EN
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
    $error("debounce_bank: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
`endif
  genvar c;
  for (c = 0; c < N_CH; c++) begin : g_ch
    debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
`ifdef DEBOUNCE_LONGPRESS_EN
      .LONG_CYCLES(LONG_CYCLES),
`endif
      .W(W)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .i_btn (button_in[c]),
      .o_out (button_out[c]),
      .o_rise(button_rise[c]),
      .o_fall(button_fall[c]),
      .o_long(button_long[c])
    );
  end
endmodule
